// File: rtl/pc_branch_unit.sv
// Program-counter stage: conditional jumps against a registered flag register,
// CALL/RET via a small return-address stack. Optional halt: PC_BRANCH_UNIT_HALT_EN.
module pc_branch_unit #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        alu_flags,
    input  logic              flags_load,
    input  logic              jmp,
    input  logic [2:0]        jmp_cond,
    input  logic [ADDR_W-1:0] target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        flags,
    output logic              stack_ovf,
    output logic              stack_unf
`ifdef PC_BRANCH_UNIT_HALT_EN
    ,
    input  logic              halt,
    output logic              halted
`endif
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] ret_stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp, sp_next;
    logic [ADDR_W-1:0] pc_next, pc_plus1, stack_top;
    logic [IDX_W-1:0]  top_idx, push_idx;
    logic              cond_true, taken;
    logic              stack_empty, stack_full;
    logic              push_en, set_ovf, set_unf;
    logic              freeze;

    logic flag_z, flag_n, flag_c;
    assign flag_z = flags[3];
    assign flag_n = flags[2];
    assign flag_c = flags[1];

`ifdef PC_BRANCH_UNIT_HALT_EN
    // A halt sampled at an edge already blocks that edge's update.
    assign freeze = halt | halted;
`else
    assign freeze = 1'b0;
`endif

    assign pc_plus1    = pc + 1'b1;
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_FULL);
    assign top_idx     = IDX_W'(sp - 1'b1);
    assign push_idx    = IDX_W'(sp);
    assign stack_top   = ret_stack[top_idx];

    always_comb begin
        cond_true = 1'b0;
        case (jmp_cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z;
            3'b011:  cond_true = !flag_z && !flag_n;
            3'b100:  cond_true = !flag_n;
            3'b101:  cond_true = flag_n;
            3'b110:  cond_true = flag_z || flag_n;
            3'b111:  cond_true = flag_c;
            default: cond_true = 1'b0;
        endcase
    end

    assign taken = jmp && cond_true;

    always_comb begin
        pc_next = pc_plus1;
        sp_next = sp;
        push_en = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (ret) begin
            if (!stack_empty) begin
                pc_next = stack_top;
                sp_next = sp - 1'b1;
            end else begin
                set_unf = 1'b1;
            end
        end else if (call) begin
            pc_next = target;
            if (!stack_full) begin
                push_en = 1'b1;
                sp_next = sp + 1'b1;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (taken) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            sp        <= '0;
            flags     <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!freeze) begin
            pc <= pc_next;
            sp <= sp_next;
            if (flags_load) flags <= alu_flags;
            if (set_ovf) stack_ovf <= 1'b1;
            if (set_unf) stack_unf <= 1'b1;
        end
    end

    // Stack contents need no reset; only sp defines validity.
    always_ff @(posedge clk) begin
        if (push_en && !freeze && !reset) ret_stack[push_idx] <= pc_plus1;
    end

`ifdef PC_BRANCH_UNIT_HALT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     halted <= 1'b0;
        else if (halt) halted <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: per-cycle vector table plus hand-written
// reset and halt sequences.
module tb_pc_branch_unit;

    logic       clk;
    logic       reset;
    logic [3:0] alu_flags;
    logic       flags_load;
    logic       jmp;
    logic [2:0] jmp_cond;
    logic [7:0] target;
    logic       call;
    logic       ret;
    logic [7:0] pc;
    logic [3:0] flags;
    logic       stack_ovf;
    logic       stack_unf;
`ifdef PC_BRANCH_UNIT_HALT_EN
    logic       halt;
    logic       halted;
`endif

    int checks = 0;
    int errors = 0;

    pc_branch_unit #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .alu_flags(alu_flags), .flags_load(flags_load),
        .jmp(jmp), .jmp_cond(jmp_cond), .target(target), .call(call), .ret(ret),
        .pc(pc), .flags(flags), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
`ifdef PC_BRANCH_UNIT_HALT_EN
        , .halt(halt), .halted(halted)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] af;
        logic       fl;
        logic       jmp;
        logic [2:0] cond;
        logic [7:0] tgt;
        logic       call;
        logic       ret;
        logic [7:0] e_pc;
        logic [3:0] e_flags;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    localparam int NV = 44;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [3:0] af, logic fl, logic j, logic [2:0] c,
                                logic [7:0] t, logic ca, logic r, logic [7:0] ep,
                                logic [3:0] ef, logic eo, logic eu);
        vec_t v;
        v.af = af; v.fl = fl; v.jmp = j; v.cond = c; v.tgt = t; v.call = ca; v.ret = r;
        v.e_pc = ep; v.e_flags = ef; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_flags = '0; flags_load = 0; jmp = 0; jmp_cond = '0;
        target = '0; call = 0; ret = 0;
`ifdef PC_BRANCH_UNIT_HALT_EN
        halt = 0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset away from the edge, released on a falling edge.
    task automatic async_reset(input string tag);
        #2 reset = 1;
        #1;
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_flags"}, flags, 0);
        chk({tag, "_ovf"}, stack_ovf, 0);
        chk({tag, "_unf"}, stack_unf, 0);
`ifdef PC_BRANCH_UNIT_HALT_EN
        chk({tag, "_halted"}, halted, 0);
`endif
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        //           af     fl j cond   tgt   ca r  e_pc   e_fl  o  u
        vecs[0]  = mk(4'h8, 1,0,3'd0,8'h00,0,0,8'h01,4'h8,0,0);
        vecs[1]  = mk(4'h0, 0,1,3'd1,8'h40,0,0,8'h40,4'h8,0,0); // EQ taken
        vecs[2]  = mk(4'h0, 0,1,3'd2,8'h50,0,0,8'h41,4'h8,0,0); // NE not taken
        vecs[3]  = mk(4'h0, 1,1,3'd0,8'h10,0,0,8'h10,4'h0,0,0); // always
        vecs[4]  = mk(4'h8, 1,1,3'd1,8'h60,0,0,8'h11,4'h8,0,0); // old Z=0
        vecs[5]  = mk(4'h0, 0,1,3'd1,8'h10,0,0,8'h10,4'h8,0,0); // new Z=1
        vecs[6]  = mk(4'h0, 0,0,3'd0,8'h80,1,0,8'h80,4'h8,0,0); // call, push 11
        vecs[7]  = mk(4'h0, 0,0,3'd0,8'h00,0,0,8'h81,4'h8,0,0);
        vecs[8]  = mk(4'h0, 0,0,3'd0,8'h00,0,0,8'h82,4'h8,0,0);
        vecs[9]  = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'h11,4'h8,0,0); // ret
        vecs[10] = mk(4'h4, 1,0,3'd0,8'h00,0,0,8'h12,4'h4,0,0);
        vecs[11] = mk(4'h0, 0,1,3'd3,8'h20,0,0,8'h13,4'h4,0,0); // GT false
        vecs[12] = mk(4'h0, 0,1,3'd4,8'h20,0,0,8'h14,4'h4,0,0); // GE false
        vecs[13] = mk(4'h0, 0,1,3'd5,8'h20,0,0,8'h20,4'h4,0,0); // LT true
        vecs[14] = mk(4'h0, 0,1,3'd6,8'h30,0,0,8'h30,4'h4,0,0); // LE true
        vecs[15] = mk(4'h2, 1,1,3'd7,8'h40,0,0,8'h31,4'h2,0,0); // CS old C=0
        vecs[16] = mk(4'h0, 0,1,3'd7,8'h40,0,0,8'h40,4'h2,0,0); // CS true
        vecs[17] = mk(4'h0, 0,1,3'd3,8'h50,0,0,8'h50,4'h2,0,0); // GT true
        vecs[18] = mk(4'h0, 0,0,3'd0,8'hA0,1,0,8'hA0,4'h2,0,0); // push 51
        vecs[19] = mk(4'h0, 0,0,3'd0,8'hB0,1,0,8'hB0,4'h2,0,0); // push A1
        vecs[20] = mk(4'h0, 0,0,3'd0,8'hC0,1,0,8'hC0,4'h2,0,0); // push B1
        vecs[21] = mk(4'h0, 0,0,3'd0,8'hD0,1,0,8'hD0,4'h2,0,0); // push C1
        vecs[22] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'hC1,4'h2,0,0);
        vecs[23] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'hB1,4'h2,0,0);
        vecs[24] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'hA1,4'h2,0,0);
        vecs[25] = mk(4'h0, 0,0,3'd0,8'hE0,1,1,8'h51,4'h2,0,0); // ret beats call
        vecs[26] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'h52,4'h2,0,1); // underflow
        vecs[27] = mk(4'h0, 0,0,3'd0,8'h00,0,0,8'h53,4'h2,0,1);
        vecs[28] = mk(4'h0, 0,0,3'd0,8'h10,1,0,8'h10,4'h2,0,1); // push 54
        vecs[29] = mk(4'h0, 0,0,3'd0,8'h20,1,0,8'h20,4'h2,0,1); // push 11
        vecs[30] = mk(4'h0, 0,0,3'd0,8'h30,1,0,8'h30,4'h2,0,1); // push 21
        vecs[31] = mk(4'h0, 0,0,3'd0,8'h40,1,0,8'h40,4'h2,0,1); // push 31
        vecs[32] = mk(4'h0, 0,0,3'd0,8'h90,1,0,8'h90,4'h2,1,1); // overflow
        vecs[33] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'h31,4'h2,1,1);
        vecs[34] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'h21,4'h2,1,1);
        vecs[35] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'h11,4'h2,1,1);
        vecs[36] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'h54,4'h2,1,1);
        vecs[37] = mk(4'h0, 0,0,3'd0,8'h00,0,0,8'h55,4'h2,1,1);
        vecs[38] = mk(4'h0, 0,1,3'd0,8'hFF,0,0,8'hFF,4'h2,1,1);
        vecs[39] = mk(4'h0, 0,0,3'd0,8'h20,1,0,8'h20,4'h2,1,1); // push 00
        vecs[40] = mk(4'h0, 0,0,3'd0,8'h00,0,0,8'h21,4'h2,1,1);
        vecs[41] = mk(4'h0, 0,0,3'd0,8'h00,0,1,8'h00,4'h2,1,1);
        vecs[42] = mk(4'h0, 0,1,3'd0,8'hFF,0,0,8'hFF,4'h2,1,1);
        vecs[43] = mk(4'h0, 0,0,3'd0,8'h00,0,0,8'h00,4'h2,1,1); // wrap

        idle_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;

        // Idle counting, then asynchronous reset mid-cycle at pc=3.
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("idle_pc%0d", i), pc, i);
        end
        async_reset("rst_mid");

        for (int i = 0; i < NV; i++) begin
            alu_flags  = vecs[i].af;
            flags_load = vecs[i].fl;
            jmp        = vecs[i].jmp;
            jmp_cond   = vecs[i].cond;
            target     = vecs[i].tgt;
            call       = vecs[i].call;
            ret        = vecs[i].ret;
            step();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_flags", i), flags, vecs[i].e_flags);
            chk($sformatf("v%0d_ovf", i), stack_ovf, vecs[i].e_ovf);
            chk($sformatf("v%0d_unf", i), stack_unf, vecs[i].e_unf);
        end
        idle_inputs();

        // Sticky error flags persist through idle cycles, clear only on reset.
        step();
        step();
        chk("sticky_ovf", stack_ovf, 1);
        chk("sticky_unf", stack_unf, 1);
        async_reset("rst_sticky");

`ifdef PC_BRANCH_UNIT_HALT_EN
        for (int i = 0; i < 5; i++) step();
        chk("halt_pre_pc", pc, 5);
        halt = 1; jmp = 1; jmp_cond = 3'd0; target = 8'h40;
        flags_load = 1; alu_flags = 4'hF;
        step();
        chk("halt_pc", pc, 5);
        chk("halt_halted", halted, 1);
        halt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("halt_hold_pc%0d", i), pc, 5);
            chk($sformatf("halt_hold_flags%0d", i), flags, 0);
            chk($sformatf("halt_hold_halted%0d", i), halted, 1);
        end
        idle_inputs();
        async_reset("rst_halt");
        step();
        chk("post_halt_pc", pc, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
